win_checker: RTL and testbench
==============================

WIN_CHECKER -- requirements
Module: win_checker

Interface
REQ-001 The module SHALL have these ports, one clock domain: clk  in  1  rising-edge clock.
REQ-002 reset  in  1  reset, synchronous and active-high.
REQ-003 check  in  1  one-cycle start pulse from the column selector after a valid drop.
REQ-004 in_gameboard  in  16  occupancy, bit = row*4+col, row 0 bottom; 1 = occupied.
REQ-005 in_players_cells  in  16  owner per cell, 0 = player 1, 1 = player 2; meaningful only where occupied.
REQ-006 busy  out  1  high while a scan is in progress.
REQ-007 done  out  1  one-cycle pulse when a result is valid.
REQ-008 winner  out  2  00 none, 01 player 1, 10 player 2, 11 draw.
REQ-009 win_line  out  4  index of the winning line, 0-9; 0 when no win.
REQ-010 game_over  out  1  sticky; high after a win or draw until reset.

Function
REQ-011 The FSM SHALL have states IDLE, SCAN, REPORT and OVER.
REQ-012 In IDLE, a sampled check SHALL snapshot both input vectors into registers, clear the line counter and enter SCAN; inputs are not read again.
REQ-013 Line order SHALL be: lines 0-3 = rows 0-3; lines 4-7 = columns 0-3; line 8 = cells 0,5,10,15; line 9 = cells 3,6,9,12.
REQ-014 In SCAN, one line SHALL be evaluated per cycle; a line hits when all 4 cells are occupied and have equal owner bits.
REQ-015 On a hit at line k, the FSM SHALL go to REPORT with winner = owner code and win_line = k; the lowest-index hit wins.
REQ-016 If line 9 evaluates without a hit, the FSM SHALL go to REPORT with winner 00, or with 11 per REQ-026.
REQ-017 done SHALL be high for exactly the REPORT cycle, k+1 cycles after the edge that sampled check, with k the hit line, or 10 with no hit.
REQ-018 busy SHALL be high in SCAN and REPORT and low in IDLE and OVER.
REQ-019 From REPORT, the FSM SHALL go to OVER if winner is not 00, and otherwise to IDLE.
REQ-020 winner and win_line SHALL hold their values until the next check is accepted or reset.
REQ-021 check SHALL be ignored in SCAN, REPORT and OVER; it is neither queued nor counted.
REQ-022 In OVER, game_over SHALL be 1 and the FSM SHALL leave OVER only on reset.

Reset
REQ-023 On reset, the FSM SHALL go to IDLE and busy, done, winner, win_line, game_over and the snapshot registers SHALL all clear to 0.
REQ-024 Reset SHALL take priority over check in the same cycle.
REQ-025 Reset during SCAN SHALL abort the scan with no done pulse.

Configuration
REQ-026 With DRAW_DETECT_EN defined, a no-hit scan with a snapshot gameboard of 16'hFFFF SHALL report winner 11 and enter OVER.
REQ-027 Without DRAW_DETECT_EN, code 11 SHALL never be produced and a full board with no hit SHALL report 00.

Structure
REQ-028 The shared package connect4_pkg SHALL hold the FSM state enum, the winner code constants and the ten 16-bit line masks.
REQ-029 A combinational sub-module, win_line_lut, SHALL map the 4-bit line index to its 16-bit mask; an index above 9 maps to 0.

Verification
REQ-030 gameboard 16'h000F, players 16'h0000, check pulse -> done 1 cycle later, winner 01, win_line 0, game_over 1.
REQ-031 gameboard 16'h4444, players 16'h4444 -> done 7 cycles after check, winner 10, win_line 6.
REQ-032 gameboard 16'h000F, players 16'h0001 -> done 10 cycles after check, winner 00, game_over 0, FSM back in IDLE.
REQ-033 gameboard 16'hFFFF, players 16'h3C3C -> after 10 cycles, winner 11 with DRAW_DETECT_EN, winner 00 without.
REQ-034 A second check 3 cycles into a scan is ignored; reset asserted at cycle 5 of a scan -> no done, all outputs 0 next cycle.
REQ-035 In OVER, a check with a new winning board -> no done, winner and win_line unchanged.

Source files
------------

// File: rtl/connect4_pkg.sv
// Shared Connect-4 (4x4) win-check definitions: FSM states, winner codes, line masks.
// Cell bit index = row*4 + col, row 0 at the bottom.
package connect4_pkg;

   localparam int         NUM_LINES = 10;
   localparam logic [3:0] LAST_LINE = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_REPORT = 2'd2,
      ST_OVER   = 2'd3
   } state_e;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   // Element k is the mask of line k: rows 0-3, columns 0-3, diagonal, anti-diagonal.
   localparam logic [NUM_LINES-1:0][15:0] LINE_MASKS = {
      16'h1248, 16'h8421,
      16'h8888, 16'h4444, 16'h2222, 16'h1111,
      16'hF000, 16'h0F00, 16'h00F0, 16'h000F
   };

   typedef struct packed {
      logic [15:0] board;
      logic [15:0] owner;
   } snap_t;

endpackage

// File: rtl/win_checker_if.sv
// Handshake/data bundle between the column selector (master) and win_checker (slave).
interface win_checker_if;
   logic        check;
   logic [15:0] in_gameboard;
   logic [15:0] in_players_cells;
   logic        busy;
   logic        done;
   logic [1:0]  winner;
   logic [3:0]  win_line;
   logic        game_over;

   modport master (
      output check, in_gameboard, in_players_cells,
      input  busy, done, winner, win_line, game_over
   );

   modport slave (
      input  check, in_gameboard, in_players_cells,
      output busy, done, winner, win_line, game_over
   );
endinterface

// File: rtl/win_line_lut.sv
// Combinational map from line index to its 16-bit cell mask; indices above 9 give 0.
module win_line_lut
   import connect4_pkg::*;
(
   input  logic [3:0]  line_idx,
   output logic [15:0] mask
);

   always_comb begin
      mask = '0;
      for (int i = 0; i < NUM_LINES; i++) begin
         if (line_idx == 4'(i)) mask = LINE_MASKS[i];
      end
   end

endmodule

// File: rtl/win_checker.sv
// Sequential 4x4 win checker: snapshots the board on check, scans one line per cycle.
// Optional DRAW_DETECT_EN: a full board with no winning line reports a draw (11).
module win_checker
   import connect4_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   win_checker_if.slave  bus
);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   snap_t       snap_q, snap_d;
   logic [1:0]  winner_q, winner_d;
   logic [3:0]  line_q, line_d;
   logic        over_q, over_d;

   logic [15:0] line_mask;
   logic [15:0] line_own;
   logic        line_hit;

   win_line_lut u_lut (
      .line_idx (cnt_q),
      .mask     (line_mask)
   );

   // A line hits when all four cells are occupied and share one owner bit.
   assign line_own = snap_q.owner & line_mask;
   assign line_hit = (line_mask != '0) &&
                     ((snap_q.board & line_mask) == line_mask) &&
                     ((line_own == '0) || (line_own == line_mask));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      snap_d   = snap_q;
      winner_d = winner_q;
      line_d   = line_q;
      over_d   = over_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.check) begin
               snap_d.board = bus.in_gameboard;
               snap_d.owner = bus.in_players_cells;
               cnt_d        = '0;
               winner_d     = WIN_NONE;
               line_d       = '0;
               state_d      = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (line_hit) begin
               winner_d = (line_own == '0) ? WIN_P1 : WIN_P2;
               line_d   = cnt_q;
               over_d   = 1'b1;
               state_d  = ST_REPORT;
            end else if (cnt_q == LAST_LINE) begin
               winner_d = WIN_NONE;
`ifdef DRAW_DETECT_EN
               if (snap_q.board == 16'hFFFF) begin
                  winner_d = WIN_DRAW;
                  over_d   = 1'b1;
               end
`endif
               state_d  = ST_REPORT;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_REPORT: state_d = (winner_q != WIN_NONE) ? ST_OVER : ST_IDLE;
         ST_OVER:   state_d = ST_OVER;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         snap_q   <= '0;
         winner_q <= WIN_NONE;
         line_q   <= '0;
         over_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         snap_q   <= snap_d;
         winner_q <= winner_d;
         line_q   <= line_d;
         over_q   <= over_d;
      end
   end

   assign bus.busy      = (state_q == ST_SCAN) || (state_q == ST_REPORT);
   assign bus.done      = (state_q == ST_REPORT);
   assign bus.winner    = winner_q;
   assign bus.win_line  = line_q;
   assign bus.game_over = over_q;

endmodule

// File: tb/tb_win_checker.sv
// Scoreboard bench for win_checker: directed corner cases plus random boards vs a cell-level model.
module tb_win_checker;

   logic clk = 1'b0;
   logic reset;

   win_checker_if bus ();

   win_checker dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] winner;
      logic [3:0] line;
      int         lat;
      int         sample_cyc;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: walk each line as a list of cell coordinates, in scan order.
   function automatic void model(input logic [15:0] b, input logic [15:0] o,
                                 output logic [1:0] w, output logic [3:0] ln, output int lat);
      int  cells[10][4];
      bit  found;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            cells[r][c]     = r * 4 + c;
            cells[4 + c][r] = r * 4 + c;
         end
      for (int i = 0; i < 4; i++) begin
         cells[8][i] = i * 5;
         cells[9][i] = 3 + i * 3;
      end
      w = 2'b00; ln = 4'd0; lat = 10; found = 0;
      for (int k = 0; k < 10; k++) begin
         int n_occ, n_p2;
         n_occ = 0; n_p2 = 0;
         for (int i = 0; i < 4; i++) begin
            if (b[cells[k][i]]) n_occ++;
            if (o[cells[k][i]]) n_p2++;
         end
         if (!found && n_occ == 4 && (n_p2 == 0 || n_p2 == 4)) begin
            found = 1;
            w     = (n_p2 == 0) ? 2'b01 : 2'b10;
            ln    = 4'(k);
            lat   = k + 1;
         end
      end
`ifdef DRAW_DETECT_EN
      if (!found && b == 16'hFFFF) w = 2'b11;
`endif
   endfunction

   // Monitor: every done must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && bus.done) begin
         if (sb.size() == 0) begin
            cmp("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            cmp("winner", 32'(bus.winner), 32'(e.winner));
            cmp("win_line", 32'(bus.win_line), 32'(e.line));
            cmp("latency", 32'(cyc - e.sample_cyc), 32'(e.lat));
         end
      end
   end

   task automatic issue(input logic [15:0] b, input logic [15:0] o, input bit accept,
                        output logic [1:0] w);
      exp_t       e;
      logic [3:0] ln;
      int         lat;
      model(b, o, w, ln, lat);
      @(posedge clk); #1;
      bus.check            = 1'b1;
      bus.in_gameboard     = b;
      bus.in_players_cells = o;
      if (accept) begin
         e.winner = w; e.line = ln; e.lat = lat; e.sample_cyc = cyc + 1;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      bus.check            = 1'b0;
      bus.in_gameboard     = $urandom;
      bus.in_players_cells = $urandom;
   endtask

   task automatic wait_done(input bit exp_over);
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         cmp("done_timeout", 32'd1, 32'd0);
         sb.delete();
      end
      @(negedge clk);
      cmp("busy_after", 32'(bus.busy), 32'd0);
      cmp("game_over_after", 32'(bus.game_over), 32'(exp_over));
   endtask

   task automatic run(input logic [15:0] b, input logic [15:0] o, output logic [1:0] w);
      issue(b, o, 1'b1, w);
      wait_done(w != 2'b00);
   endtask

   task automatic do_reset(input bit with_check);
      @(posedge clk); #1;
      reset                = 1'b1;
      bus.check            = with_check;
      bus.in_gameboard     = 16'h000F;
      bus.in_players_cells = 16'h0000;
      sb.delete();
      @(posedge clk); #1;
      reset     = 1'b0;
      bus.check = 1'b0;
      cmp("rst_busy", 32'(bus.busy), 32'd0);
      cmp("rst_done", 32'(bus.done), 32'd0);
      cmp("rst_winner", 32'(bus.winner), 32'd0);
      cmp("rst_win_line", 32'(bus.win_line), 32'd0);
      cmp("rst_game_over", 32'(bus.game_over), 32'd0);
   endtask

   initial begin
      logic [1:0]  w;
      logic [15:0] b;
      reset                = 1'b1;
      bus.check            = 1'b0;
      bus.in_gameboard     = '0;
      bus.in_players_cells = '0;
      repeat (2) @(posedge clk);
      do_reset(1'b0);

      // Directed cases: bottom row, column 2 player 2, no-win, full board.
      run(16'h000F, 16'h0000, w);
      do_reset(1'b0);
      run(16'h4444, 16'h4444, w);
      do_reset(1'b0);
      run(16'h000F, 16'h0001, w);
      run(16'hFFFF, 16'h3C3C, w);
      do_reset(1'b0);

      // Second check mid-scan is ignored.
      issue(16'h000F, 16'h0001, 1'b1, w);
      @(posedge clk);
      issue(16'h000F, 16'h0000, 1'b0, w);
      wait_done(1'b0);

      // Reset in the middle of a scan aborts it silently.
      issue(16'h000F, 16'h0001, 1'b1, w);
      repeat (3) @(posedge clk);
      do_reset(1'b0);
      repeat (12) @(negedge clk);
      cmp("abort_busy", 32'(bus.busy), 32'd0);

      // Game over: a later winning check is ignored.
      run(16'h000F, 16'h0000, w);
      issue(16'hF000, 16'hF000, 1'b0, w);
      repeat (14) @(negedge clk);
      cmp("over_winner", 32'(bus.winner), 32'd1);
      cmp("over_win_line", 32'(bus.win_line), 32'd0);
      cmp("over_game_over", 32'(bus.game_over), 32'd1);
      cmp("over_busy", 32'(bus.busy), 32'd0);

      // Reset wins over a simultaneous check.
      do_reset(1'b1);
      repeat (3) @(negedge clk);
      cmp("rst_prio_busy", 32'(bus.busy), 32'd0);

      for (int it = 0; it < 60; it++) begin
         case ($urandom_range(2, 0))
            0:       b = 16'($urandom);
            1:       b = 16'hFFFF;
            default: b = 16'($urandom) & 16'($urandom);
         endcase
         run(b, 16'($urandom), w);
         if (w != 2'b00) do_reset(1'b0);
      end

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
